// File: rtl/serial_frame_rx.sv
// Asynchronous serial frame receiver: start, 5 data bits (b1 first), parity, stop.
// Presents the last good frame as held, registered levels for the display stage.
module serial_frame_rx #(
    parameter int   CLKS_PER_BIT = 16,
    parameter logic IDLE_LEVEL   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    output logic b1,
    output logic b2,
    output logic b3,
    output logic b4,
    output logic b5,
    output logic b_par,
    output logic frame_valid,
    output logic frame_err,
    output logic busy
);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF = CW'(H);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [4:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [5:0]    out_q, out_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          rx_s;

    assign sync_d = {sync_q[0], rx_in};
    assign rx_s   = sync_q[1];

    // cnt_q counts cycles since the last sample point (or since t0), so a
    // sample is due when it reaches H in START and N in the later states.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        out_d   = out_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_s != IDLE_LEVEL) begin
                    state_d = START;
                    cnt_d   = CW'(1);
                    bit_d   = 3'd0;
                end
            end
            START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = CW'(1);
                    state_d = (rx_s == IDLE_LEVEL) ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d   = CW'(1);
                    shift_d = {shift_q[3:0], rx_s};
                    if (bit_q == 3'd4) state_d = PARITY;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PARITY: begin
                if (cnt_q == FULL) begin
                    cnt_d   = CW'(1);
                    par_d   = rx_s;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d = CW'(1);
                    if (rx_s == IDLE_LEVEL) begin
                        out_d   = {shift_q, par_q};
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_IDLE: begin
                // a line stuck at the start level must not retrigger a frame
                if (rx_s == IDLE_LEVEL) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sync_q  <= {2{IDLE_LEVEL}};
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign {b1, b2, b3, b4, b5, b_par} = out_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign busy        = (state_q != IDLE);
endmodule
